// File: rtl/xor_cipher_pkg.sv
// Shared constants for the XOR cipher configuration sequencer: chain geometry, FSM encoding and
// config field offsets inside the 131-bit chain.
package xor_cipher_pkg;

  localparam int unsigned CFG_BITS = 131;
  localparam int unsigned NBYTES   = 17;

  localparam logic [4:0] LAST_BYTE = 5'(NBYTES - 1);
  localparam logic [7:0] LAST_BIT  = 8'(CFG_BITS - 1);

  // Config field offsets within the chain
  localparam int unsigned K_MUX     = 130;
  localparam int unsigned A_MUX     = 129;
  localparam int unsigned D_EN      = 128;
  localparam int unsigned TAPS_LSB  = 64;
  localparam int unsigned STATE_LSB = 0;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StFill   = 3'd1;
  localparam state_t StShift  = 3'd2;
  localparam state_t StSettle = 3'd3;
  localparam state_t StRun    = 3'd4;

endpackage

// File: rtl/xor_cipher_cfg_sequencer_serializer.sv
// Image buffer and serial shifter: streams the buffered image into the core chain bit 0 first
// while capturing the core's previous contents into the readback buffer.
module cfg_byte_serializer
  import xor_cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_idx,
  input  logic [7:0] wr_byte,
  input  logic       shift_start,
  input  logic       cfg_o,
  input  logic [4:0] rb_sel,
  output logic       cfg_en,
  output logic       cfg_i,
  output logic       shift_last,
  output logic [7:0] rb_byte
);

  logic [7:0] image_q    [NBYTES];
  logic [7:0] readback_q [NBYTES];
  logic [7:0] bit_cnt_q;
  logic [7:0] bit_nxt;
  logic       cfg_en_q;
  logic       cfg_i_q;
  logic [7:0] rb_byte_q;

  assign bit_nxt = bit_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        image_q[i]    <= '0;
        readback_q[i] <= '0;
      end
      bit_cnt_q <= '0;
      cfg_en_q  <= 1'b0;
      cfg_i_q   <= 1'b0;
      rb_byte_q <= '0;
    end else begin
      if (wr_en) begin
        image_q[wr_idx] <= wr_byte;
      end
      // Byte 0 is already buffered when the final byte lands, so bit 0 can be presented at once
      if (shift_start) begin
        cfg_en_q  <= 1'b1;
        cfg_i_q   <= image_q[0][0];
        bit_cnt_q <= '0;
      end else if (cfg_en_q) begin
        readback_q[bit_cnt_q[7:3]][bit_cnt_q[2:0]] <= cfg_o;
        if (bit_cnt_q == LAST_BIT) begin
          cfg_en_q  <= 1'b0;
          cfg_i_q   <= 1'b0;
          bit_cnt_q <= '0;
        end else begin
          cfg_i_q   <= image_q[bit_nxt[7:3]][bit_nxt[2:0]];
          bit_cnt_q <= bit_nxt;
        end
      end
      rb_byte_q <= (rb_sel <= LAST_BYTE) ? readback_q[rb_sel] : 8'h00;
    end
  end

  assign cfg_en     = cfg_en_q;
  assign cfg_i      = cfg_i_q;
  assign shift_last = cfg_en_q && (bit_cnt_q == LAST_BIT);
  assign rb_byte    = rb_byte_q;

endmodule

// File: rtl/xor_cipher_cfg_sequencer.sv
// Host-side config sequencer for the XOR cipher core: buffers a 17-byte image, shifts it into
// the core's config chain, settles, then gates the core run enable from run_req.
module xor_cipher_cfg_sequencer
  import xor_cipher_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FILL_TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       run_req,
  input  logic       abort,
  output logic       cfg_en,
  output logic       cfg_i,
  input  logic       cfg_o,
  output logic       cipher_en,
  input  logic [4:0] rb_sel,
  output logic [7:0] rb_byte,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t     state_q, state_d;
  logic [4:0] byte_cnt_q, byte_cnt_d;
  logic [9:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       cipher_en_q, cipher_en_d;

  logic       xfer;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic       shift_start;
  logic       shift_last;

  assign wr_ready = (state_q == StIdle) || (state_q == StFill) || (state_q == StRun);
  assign xfer     = wr_valid && wr_ready;

  // cnt_q doubles as the FILL idle-gap counter and the SETTLE delay counter
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    cipher_en_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = byte_cnt_q;
    shift_start = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        if (state_q == StRun) begin
          cipher_en_d = run_req;
        end
        if (xfer) begin
          cipher_en_d = 1'b0;
          wr_en       = 1'b1;
          wr_idx      = '0;
          byte_cnt_d  = 5'd1;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = StFill;
        end
      end
      StFill: begin
        if (abort) begin
          state_d    = StIdle;
          err_d      = 1'b1;
          byte_cnt_d = '0;
          cnt_d      = '0;
        end else if (xfer) begin
          wr_en      = 1'b1;
          cnt_d      = '0;
          byte_cnt_d = byte_cnt_q + 5'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            shift_start = 1'b1;
            byte_cnt_d  = '0;
            state_d     = StShift;
          end
        end else if (cnt_q == 10'(FILL_TIMEOUT - 1)) begin
          state_d    = StIdle;
          err_d      = 1'b1;
          byte_cnt_d = '0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StShift: begin
        if (shift_last) begin
          cnt_d   = '0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 10'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      cipher_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
      cipher_en_q <= cipher_en_d;
    end
  end

  cfg_byte_serializer u_serializer (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_byte     (wr_data),
    .shift_start (shift_start),
    .cfg_o       (cfg_o),
    .rb_sel      (rb_sel),
    .cfg_en      (cfg_en),
    .cfg_i       (cfg_i),
    .shift_last  (shift_last),
    .rb_byte     (rb_byte)
  );

  assign cipher_en = cipher_en_q;
  assign busy      = (state_q != StIdle) && (state_q != StRun);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_xor_cipher_cfg_sequencer.sv
// Randomized scoreboard bench: a behavioural core chain plus a "readback = previous config"
// model; a monitor process checks shifted bits, shift length, done timing and readback bytes.
module tb_xor_cipher_cfg_sequencer;
  import xor_cipher_pkg::*;

  localparam int unsigned SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       run_req = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_en, cfg_i, cfg_o, cipher_en;
  logic [4:0] rb_sel = '0;
  logic [7:0] rb_byte;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  bit         exp_bits[$];
  logic [7:0] rb_q[$];
  int         done_pend = 0;
  int         done_seen = 0;
  bit         rb_req = 1'b0;
  bit         rb_req_d = 1'b0;

  logic [CFG_BITS-1:0] chain;
  logic [CFG_BITS-1:0] core_cfg = '0;
  logic [135:0]        exp_rb = '0;

  xor_cipher_cfg_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .FILL_TIMEOUT  (1023)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .run_req   (run_req),
    .abort     (abort),
    .cfg_en    (cfg_en),
    .cfg_i     (cfg_i),
    .cfg_o     (cfg_o),
    .cipher_en (cipher_en),
    .rb_sel    (rb_sel),
    .rb_byte   (rb_byte),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Cipher core config chain: first bit shifted in ends up at position 0
  always @(posedge clk) begin
    if (rst) chain <= '0;
    else if (cfg_en) chain <= {cfg_i, chain[CFG_BITS-1:1]};
  end
  assign cfg_o = chain[0];

  always @(posedge clk) rb_req_d <= rb_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an output
  int ncyc = 0;
  int last_cfg = 0;
  int run_len = 0;
  bit run_rst = 1'b0;
  always @(negedge clk) begin
    ncyc++;
    checks++;
    assert (!(cfg_en && cipher_en)) else begin
      errors++;
      $display("FAIL overlap: cfg_en=%0b cipher_en=%0b both set at %0t", cfg_en, cipher_en, $time);
    end
    if (cfg_en) begin
      run_len++;
      last_cfg = ncyc;
      if (rst) run_rst = 1'b1;
      if (exp_bits.size() == 0) begin
        chk("unexpected_cfg_en", 1, 0);
      end else begin
        chk("cfg_i_bit", {cfg_i, busy}, {exp_bits.pop_front(), 1'b1});
      end
    end else if (run_len > 0) begin
      if (!run_rst) chk("cfg_en_run_len", run_len, CFG_BITS);
      run_len = 0;
      run_rst = 1'b0;
    end
    if (done) begin
      done_seen++;
      if (done_pend == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        done_pend--;
        chk("done_delay", ncyc - last_cfg, SETTLE + 1);
      end
    end
    if (rb_req_d) begin
      if (rb_q.size() == 0) chk("rb_queue_empty", 1, 0);
      else chk("rb_byte", rb_byte, rb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok = 1'b0;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) tick();
    else chk("wr_ready_timeout", 0, 1);
  endtask

  // Model: the new image becomes the core config; readback shows what the core held before
  task automatic commit(input logic [135:0] img);
    for (int i = 0; i < int'(CFG_BITS); i++) exp_bits.push_back(img[i]);
    done_pend++;
    exp_rb   = {5'b0, core_cfg};
    core_cfg = img[CFG_BITS-1:0];
  endtask

  task automatic load(input logic [135:0] img);
    for (int b = 0; b < int'(NBYTES); b++) send_byte(img[8*b+:8]);
    wr_valid = 1'b0;
    commit(img);
  endtask

  task automatic wait_done();
    int start = done_seen;
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (done_seen > start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic rb_read(input logic [4:0] sel);
    rb_sel = sel;
    rb_req = 1'b1;
    rb_q.push_back((sel < 5'd17) ? exp_rb[8*sel+:8] : 8'h00);
    tick();
    rb_req = 1'b0;
  endtask

  task automatic rb_all();
    for (int s = 0; s < 17; s++) rb_read(5'(s));
    rb_read(5'd17);
    rb_read(5'd31);
    tick();
  endtask

  function automatic logic [135:0] rand_img();
    logic [135:0] img;
    for (int b = 0; b < 17; b++) img[8*b+:8] = 8'($urandom);
    return img;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [135:0] img;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", {wr_ready, cfg_en, cfg_i, cipher_en, busy, done, err, rb_byte},
        {1'b1, 6'b0, 8'h00});

    // Default image, then run_req gating with one cycle of latency
    img = '0;
    img[STATE_LSB+:64] = 64'h55;
    img[TAPS_LSB+:64]  = 64'h4800_0000;
    load(img);
    wait_done();
    run_req = 1'b1;
    tick();
    chk("cipher_en_on", cipher_en, 1);
    run_req = 1'b0;
    tick();
    chk("cipher_en_off", cipher_en, 0);
    rb_all();

    // Image A then image B: readback must show A
    img = rand_img();
    img[K_MUX] = 1'b1;
    load(img);
    wait_done();
    load(rand_img());
    wait_done();
    rb_all();

    // Fill timeout after 5 bytes
    for (int b = 0; b < 5; b++) send_byte(8'($urandom));
    wr_valid = 1'b0;
    repeat (1022) @(posedge clk);
    #1;
    chk("timeout_not_yet", {err, busy}, 2'b01);
    tick();
    chk("timeout_hit", {err, busy}, 2'b10);

    // Abort on byte 9, then abort coinciding with the final byte
    img = rand_img();
    for (int b = 0; b < 9; b++) send_byte(img[8*b+:8]);
    abort = 1'b1;
    wr_data = img[79:72];
    tick();
    abort = 1'b0;
    wr_valid = 1'b0;
    chk("abort_fill", {err, busy}, 2'b10);
    for (int b = 0; b < 16; b++) send_byte(img[8*b+:8]);
    chk("err_cleared_by_byte0", err, 0);
    abort = 1'b1;
    wr_data = img[135:128];
    tick();
    abort = 1'b0;
    wr_valid = 1'b0;
    chk("abort_last_byte", {err, busy}, 2'b10);
    repeat (4) tick();

    // Abort during SHIFT is ignored
    load(img);
    repeat (60) @(posedge clk);
    #1 abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    wait_done();
    chk("err_after_shift_abort", err, 0);

    // Reconfigure from RUN with run_req held
    run_req = 1'b1;
    tick();
    chk("run_cipher_en", cipher_en, 1);
    img = rand_img();
    send_byte(img[7:0]);
    chk("reconf_drop", {cipher_en, busy}, 2'b01);
    for (int b = 1; b < 17; b++) send_byte(img[8*b+:8]);
    wr_valid = 1'b0;
    commit(img);
    wait_done();
    tick();
    chk("rerun_cipher_en", cipher_en, 1);
    run_req = 1'b0;
    rb_all();

    // Reset in the middle of SHIFT
    load(rand_img());
    repeat (70) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_bits.delete();
    done_pend = 0;
    core_cfg = '0;
    exp_rb = '0;
    chk("mid_shift_reset", {wr_ready, cfg_en, cfg_i, cipher_en, busy, done, err, rb_byte},
        {1'b1, 6'b0, 8'h00});
    load(rand_img());
    wait_done();
    rb_all();

    repeat (5) tick();
    chk("exp_bits_drained", exp_bits.size(), 0);
    chk("rb_q_drained", rb_q.size(), 0);
    chk("done_pend_drained", done_pend, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
